pb_write_sched: RTL and testbench
=================================

# pb_write_sched

Write-port scheduler for the 4-bit dual-port pixel buffer, running on the VGA pixel clock. It shares the buffer's single write port between two pixel-writing clients using round-robin arbitration. It also contains a clear/fill sequencer that sweeps every pixel location with a constant colour. The read port remains owned by the VGA controller; this block drives only the write address, write data and write enable.

## Interface
- ADDR_W, 15, pixel buffer address width
- DATA_W, 4, pixel data width
- DEPTH, 19200, number of valid pixel locations (160x120); addresses 0..DEPTH-1
- VGA_CLK  in  1  pixel clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- CLR_START  in  1  one-cycle pulse; request a full-buffer fill
- CLR_DATA  in  DATA_W  fill colour, sampled with CLR_START
- CLR_BUSY  out  1  high while the fill sweep is running
- CLR_DONE  out  1  one-cycle pulse, coincident with the last fill write on PB_WE
- REQ0_VALID / REQ1_VALID  in  1  client write request
- REQ0_ADDR / REQ1_ADDR  in  ADDR_W  client pixel address
- REQ0_DATA / REQ1_DATA  in  DATA_W  client pixel value
- REQ0_READY / REQ1_READY  out  1  grant; a transfer occurs when VALID && READY
- PB_WA  out  ADDR_W  registered write address to the pixel buffer
- PB_DATA  out  DATA_W  registered write data
- PB_WE  out  1  registered write enable

## Operation
- Two states: IDLE (arbitrate clients) and CLEAR (fill sweep).
- IDLE with CLR_START=1:
  - Latch CLR_DATA, zero the counter, go to CLEAR.
  - Both READY outputs are low in this cycle; the fill takes priority over any pending request.
- IDLE with CLR_START=0: at most one grant per cycle.
  - READYk is a combinational function of the VALIDs, the state, CLR_START and the priority pointer PRI.
  - Both clients valid: grant requester PRI.
  - One client valid: grant that client.
  - After any grant to requester k: PRI <= 1-k.
  - Reset value: PRI=0.
- Accepted client write:
  - ADDR < DEPTH: PB_WE=1 next cycle, with that address and data.
  - ADDR >= DEPTH: the handshake still completes, but the write is dropped (PB_WE stays 0). This is not an error condition.
- CLEAR:
  - Both READY outputs are low; CLR_START is ignored.
  - One write per cycle at address = counter, data = latched colour.
  - The counter increments by 1 each cycle. On issuing DEPTH-1, return to IDLE.
- CLR_BUSY = (state == CLEAR).
- While VALID is high and READY is low, clients must hold ADDR and DATA stable. The block does not rely on this.
- Reset (including mid-sweep):
  - State IDLE, counter 0, PRI 0.
  - PB_WE=0, PB_WA=0, PB_DATA=0, CLR_BUSY=0, CLR_DONE=0.
  - An aborted sweep never produces CLR_DONE.

## Timing
- Client path latency is 1 cycle: handshake in cycle t -> PB_WE/PB_WA/PB_DATA valid in cycle t+1.
- Sustained client throughput is 1 write per cycle. When both clients are continuously valid, grants alternate strictly 0,1,0,1 (starting from PRI).
- Fill sequence, with CLR_START sampled in cycle t:
  - CLR_BUSY is high during cycles t+1..t+DEPTH.
  - Fill writes appear on PB_WE during cycles t+2..t+DEPTH+1, with addresses 0..DEPTH-1 in order and no gaps.
  - CLR_DONE is high in cycle t+DEPTH+1 only.
  - The earliest client grant is in cycle t+DEPTH+1; its write appears in t+DEPTH+2. The write port therefore never sees contention.
- PB_* outputs are driven from flops only, with no combinational path from inputs. READY outputs are combinational.

## Structure
- Shared package pb_pkg:
  - Constants PB_ADDR_W=15, PB_DATA_W=4, PB_DEPTH=19200.
  - State typedef {PB_IDLE, PB_CLEAR}.
  - This package is also used by future drawing clients.
- Sub-module rr_arb2: 2-input round-robin arbiter holding the PRI flop.
  - Inputs: VALID[1:0], enable.
  - Output: one-hot grant[1:0].
  - The enable input is forced low in CLEAR and whenever CLR_START is high in IDLE.
- The counter width is ADDR_W. Wrap beyond DEPTH-1 never occurs because the terminal compare ends the sweep.

## Test plan
- Reset then idle: PB_WE=0, READY both 0, CLR_BUSY=0 for 10 cycles.
- REQ0 only, ADDR=0x0123, DATA=0x7: READY0=1 in the same cycle; the next cycle shows PB_WE=1, PB_WA=0x0123, PB_DATA=0x7.
- Both clients held valid for 6 cycles after reset: grants are 0,1,0,1,0,1, and PB_WA alternates between the two clients' addresses.
- Fill test:
  - Stimulus: CLR_START with CLR_DATA=0xA while REQ1 is valid.
  - Required: REQ1 is not granted until CLR_DONE.
  - Required: PB_WE writes 0xA to addresses 0..19199 on consecutive cycles.
  - Required: CLR_DONE coincides with PB_WA=19199.
  - Required: REQ1 is granted in the CLR_DONE cycle.
- RESET asserted at counter=500 mid-fill: the next cycle has all outputs 0 and state IDLE, and no CLR_DONE follows. A new CLR_START then restarts the sweep from address 0.
- REQ0 with ADDR=19200 (out of range): READY0=1, PB_WE stays 0. A CLR_START issued while CLR_BUSY is high is ignored, and the sweep length stays 19200.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared pixel-buffer definitions: geometry of the 160x120 4-bit buffer and the
// write-scheduler state type. Drawing clients import this package too, so they
// agree with the scheduler on address width, data width and the valid range.
package pb_pkg;

    localparam int PB_ADDR_W = 15;
    localparam int PB_DATA_W = 4;
    localparam int PB_DEPTH  = 19200;   // 160 x 120 pixel locations

    typedef enum logic {
        PB_IDLE  = 1'b0,                // arbitrating client writes
        PB_CLEAR = 1'b1                 // sweeping the whole buffer with one colour
    } pb_state_t;

endpackage

// File: rtl/pb_write_sched_rr_arb2.sv
// 2-input round-robin arbiter; holds the priority pointer for the write port.
// Latency: grant is combinational from valid/enable; the pointer updates on the clock.
// Backpressure: no grant while enable is low; the losing requester is served next.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset (pointer returns to 0)
//   valid[1:0]  : request lines
//   enable      : when low, no grant is issued and the pointer holds
//   grant[1:0]  : one-hot (or zero) grant
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // pri names the requester that wins when both are valid.
    logic pri;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = pri ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    // After serving requester k, the other one gets priority. This holds even
    // when k won uncontested, so strict alternation starts from the pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pri <= 1'b0;
        end else if (grant[0]) begin
            pri <= 1'b1;
        end else if (grant[1]) begin
            pri <= 1'b0;
        end
    end

endmodule

// File: rtl/pb_write_sched.sv
// Write-port scheduler for the pixel buffer: round-robin between two clients plus a fill sweep.
// Latency: 1 cycle from handshake (or sweep step) to the registered PB_WE/PB_WA/PB_DATA.
// Backpressure: READY is low for both clients while a fill runs or is being started.
//
// Ports:
//   VGA_CLK, RESET            : pixel clock and synchronous active-high reset
//   CLR_START, CLR_DATA       : fill request pulse and fill colour (sampled together)
//   CLR_BUSY, CLR_DONE        : sweep running; one-cycle pulse with the last fill write
//   REQk_VALID/ADDR/DATA      : client write request, k = 0/1
//   REQk_READY                : client grant (combinational)
//   PB_WA, PB_DATA, PB_WE     : registered write port of the pixel buffer
module pb_write_sched
    import pb_pkg::*;
#(
    parameter int ADDR_W = PB_ADDR_W,
    parameter int DATA_W = PB_DATA_W,
    parameter int DEPTH  = PB_DEPTH
) (
    input  logic              VGA_CLK,
    input  logic              RESET,

    input  logic              CLR_START,
    input  logic [DATA_W-1:0] CLR_DATA,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,

    input  logic              REQ0_VALID,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_DATA,
    output logic              REQ0_READY,

    input  logic              REQ1_VALID,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_DATA,
    output logic              REQ1_READY,

    output logic [ADDR_W-1:0] PB_WA,
    output logic [DATA_W-1:0] PB_DATA,
    output logic              PB_WE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

    pb_state_t         state;
    logic [ADDR_W-1:0] cnt;          // next fill address to issue
    logic [DATA_W-1:0] clr_colour;   // colour latched at CLR_START
    logic [1:0]        grant;
    logic              arb_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A starting fill wins over any pending client in the same cycle, so the
    // arbiter is muted (and its pointer frozen) both in CLEAR and on CLR_START.
    assign arb_en = (state == PB_IDLE) && !CLR_START;

    rr_arb2 u_arb (
        .clk    (VGA_CLK),
        .reset  (RESET),
        .valid  ({REQ1_VALID, REQ0_VALID}),
        .enable (arb_en),
        .grant  (grant)
    );

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];
    assign CLR_BUSY   = (state == PB_CLEAR);

    // Grant is one-hot, so selecting on grant[1] alone is enough.
    assign sel_addr = grant[1] ? REQ1_ADDR : REQ0_ADDR;
    assign sel_data = grant[1] ? REQ1_DATA : REQ0_DATA;

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            state      <= PB_IDLE;
            cnt        <= '0;
            clr_colour <= '0;
            PB_WE      <= 1'b0;
            PB_WA      <= '0;
            PB_DATA    <= '0;
            CLR_DONE   <= 1'b0;
        end else begin
            PB_WE    <= 1'b0;
            CLR_DONE <= 1'b0;
            case (state)
                PB_IDLE: begin
                    if (CLR_START) begin
                        clr_colour <= CLR_DATA;
                        cnt        <= '0;
                        state      <= PB_CLEAR;
                    end else if ((grant != 2'b00) && (sel_addr < ADDR_LIMIT)) begin
                        // Out-of-range addresses still handshake but are
                        // silently dropped here.
                        PB_WE   <= 1'b1;
                        PB_WA   <= sel_addr;
                        PB_DATA <= sel_data;
                    end
                end
                PB_CLEAR: begin
                    PB_WE   <= 1'b1;
                    PB_WA   <= cnt;
                    PB_DATA <= clr_colour;
                    // The terminal compare ends the sweep, so cnt never wraps.
                    if (cnt == LAST_ADDR) begin
                        CLR_DONE <= 1'b1;
                        cnt      <= '0;
                        state    <= PB_IDLE;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_write_sched.sv
module tb_pb_write_sched;

    localparam int DEPTH = 19200;

    logic        VGA_CLK;
    logic        RESET;
    logic        CLR_START;
    logic [3:0]  CLR_DATA;
    logic        CLR_BUSY;
    logic        CLR_DONE;
    logic        REQ0_VALID, REQ1_VALID;
    logic [14:0] REQ0_ADDR, REQ1_ADDR;
    logic [3:0]  REQ0_DATA, REQ1_DATA;
    logic        REQ0_READY, REQ1_READY;
    logic [14:0] PB_WA;
    logic [3:0]  PB_DATA;
    logic        PB_WE;

    int n_cmp  = 0;
    int n_fail = 0;

    pb_write_sched dut (
        .VGA_CLK    (VGA_CLK),
        .RESET      (RESET),
        .CLR_START  (CLR_START),
        .CLR_DATA   (CLR_DATA),
        .CLR_BUSY   (CLR_BUSY),
        .CLR_DONE   (CLR_DONE),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_ADDR  (REQ0_ADDR),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_ADDR  (REQ1_ADDR),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .PB_WA      (PB_WA),
        .PB_DATA    (PB_DATA),
        .PB_WE      (PB_WE)
    );

    initial begin
        VGA_CLK = 1'b0;
        forever #5 VGA_CLK = ~VGA_CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge VGA_CLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks the fill as "next address to write" and the
    // arbiter as "who was served last"; predicts READY for the current
    // cycle and the write port contents for the next one.
    // ------------------------------------------------------------------
    bit          armed = 1'b0;
    int          fill_pos = -1;     // -1: no fill running
    int          last_g = 1;
    logic [3:0]  colour = '0;
    logic        e_we = 1'b0, e_done = 1'b0;
    logic [14:0] e_wa = '0;
    logic [3:0]  e_data = '0;

    always @(negedge VGA_CLK) begin
        int  g;
        bit  busy;
        if (RESET) begin
            armed    = 1'b1;
            fill_pos = -1;
            last_g   = 1;
            e_we     = 1'b0;
            e_done   = 1'b0;
        end else if (armed) begin
            busy = (fill_pos >= 0);
            g = -1;
            if (!busy && !CLR_START) begin
                if (REQ0_VALID && REQ1_VALID) g = 1 - last_g;
                else if (REQ0_VALID)          g = 0;
                else if (REQ1_VALID)          g = 1;
            end
            chk("m_ready0", 32'(REQ0_READY), 32'(g == 0));
            chk("m_ready1", 32'(REQ1_READY), 32'(g == 1));
            chk("m_we",     32'(PB_WE),      32'(e_we));
            chk("m_busy",   32'(CLR_BUSY),   32'(busy));
            chk("m_done",   32'(CLR_DONE),   32'(e_done));
            if (e_we) begin
                chk("m_wa",   32'(PB_WA),   32'(e_wa));
                chk("m_data", 32'(PB_DATA), 32'(e_data));
            end
            e_done = 1'b0;
            if (busy) begin
                e_we   = 1'b1;
                e_wa   = 15'(fill_pos);
                e_data = colour;
                if (fill_pos == DEPTH - 1) begin
                    e_done   = 1'b1;
                    fill_pos = -1;
                end else begin
                    fill_pos = fill_pos + 1;
                end
            end else if (CLR_START) begin
                colour   = CLR_DATA;
                fill_pos = 0;
                e_we     = 1'b0;
            end else if (g >= 0) begin
                last_g = g;
                e_wa   = (g == 1) ? REQ1_ADDR : REQ0_ADDR;
                e_data = (g == 1) ? REQ1_DATA : REQ0_DATA;
                e_we   = (int'(e_wa) < DEPTH);
            end else begin
                e_we = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    initial begin
        int exp_g[6];
        int nw, bad, early, nb, hits;
        bit got, found;

        exp_g = '{0, 1, 0, 1, 0, 1};
        RESET = 1'b1; CLR_START = 1'b0; CLR_DATA = '0;
        REQ0_VALID = 1'b0; REQ0_ADDR = '0; REQ0_DATA = '0;
        REQ1_VALID = 1'b0; REQ1_ADDR = '0; REQ1_DATA = '0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset state, then 10 idle cycles
        @(negedge VGA_CLK);
        chk("rst_wa",   32'(PB_WA),   32'h0);
        chk("rst_data", 32'(PB_DATA), 32'h0);
        chk("rst_done", 32'(CLR_DONE), 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_we",    32'(PB_WE),    32'h0);
            chk("idle_rdy",   32'({REQ1_READY, REQ0_READY}), 32'h0);
            chk("idle_busy",  32'(CLR_BUSY), 32'h0);
            @(negedge VGA_CLK);
        end

        // Single client write
        tick();
        REQ0_VALID = 1'b1; REQ0_ADDR = 15'h0123; REQ0_DATA = 4'h7;
        @(negedge VGA_CLK);
        chk("single_rdy0", 32'(REQ0_READY), 32'h1);
        tick();
        REQ0_VALID = 1'b0;
        @(negedge VGA_CLK);
        chk("single_we",   32'(PB_WE),   32'h1);
        chk("single_wa",   32'(PB_WA),   32'h0123);
        chk("single_data", 32'(PB_DATA), 32'h7);

        // Both clients valid right after reset: strict alternation from 0
        tick(); RESET = 1'b1;
        tick(); RESET = 1'b0;
        REQ0_VALID = 1'b1; REQ0_ADDR = 15'h0AAA; REQ0_DATA = 4'h1;
        REQ1_VALID = 1'b1; REQ1_ADDR = 15'h1555; REQ1_DATA = 4'h2;
        for (int i = 0; i < 6; i++) begin
            @(negedge VGA_CLK);
            chk("alt_rdy0", 32'(REQ0_READY), 32'(exp_g[i] == 0));
            chk("alt_rdy1", 32'(REQ1_READY), 32'(exp_g[i] == 1));
            if (i > 0) chk("alt_wa", 32'(PB_WA), (exp_g[i-1] == 1) ? 32'h1555 : 32'h0AAA);
            tick();
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;

        // Fill while REQ1 waits
        REQ1_VALID = 1'b1; REQ1_ADDR = 15'h0042; REQ1_DATA = 4'h3;
        CLR_START = 1'b1; CLR_DATA = 4'hA;
        @(negedge VGA_CLK);
        chk("fill_start_rdy1", 32'(REQ1_READY), 32'h0);
        tick();
        CLR_START = 1'b0;
        nw = 0; bad = 0; early = 0; got = 1'b0;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(negedge VGA_CLK);
            if (PB_WE) begin
                if (int'(PB_WA) != nw || PB_DATA != 4'hA) bad++;
                nw++;
            end
            if (REQ1_READY && !CLR_DONE) early++;
            if (CLR_DONE) got = 1'b1;
        end
        chk("fill_done_seen", 32'(got),  32'h1);
        chk("fill_done_wa",   32'(PB_WA), 32'd19199);
        chk("fill_done_rdy1", 32'(REQ1_READY), 32'h1);
        chk("fill_writes",    32'(nw),    32'd19200);
        chk("fill_bad",       32'(bad),   32'h0);
        chk("fill_early",     32'(early), 32'h0);
        tick();
        REQ1_VALID = 1'b0;
        @(negedge VGA_CLK);
        chk("post_fill_we",   32'(PB_WE),   32'h1);
        chk("post_fill_wa",   32'(PB_WA),   32'h0042);
        chk("post_fill_data", 32'(PB_DATA), 32'h3);

        // Reset while the sweep counter is at 500
        tick();
        CLR_START = 1'b1; CLR_DATA = 4'h5;
        tick();
        CLR_START = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge VGA_CLK);
            if (PB_WE && PB_WA == 15'd498) found = 1'b1;
        end
        chk("abort_sync", 32'(found), 32'h1);
        tick(); RESET = 1'b1;
        tick(); RESET = 1'b0;
        @(negedge VGA_CLK);
        chk("abort_we",   32'(PB_WE),    32'h0);
        chk("abort_wa",   32'(PB_WA),    32'h0);
        chk("abort_data", 32'(PB_DATA),  32'h0);
        chk("abort_busy", 32'(CLR_BUSY), 32'h0);
        chk("abort_done", 32'(CLR_DONE), 32'h0);
        hits = 0;
        for (int c = 0; c < 19300; c++) begin
            @(negedge VGA_CLK);
            if (CLR_DONE || PB_WE) hits++;
        end
        chk("abort_quiet", 32'(hits), 32'h0);

        // Out-of-range client address is accepted and dropped
        tick();
        REQ0_VALID = 1'b1; REQ0_ADDR = 15'd19200; REQ0_DATA = 4'hF;
        @(negedge VGA_CLK);
        chk("oor_rdy0", 32'(REQ0_READY), 32'h1);
        tick();
        REQ0_VALID = 1'b0;
        @(negedge VGA_CLK);
        chk("oor_we", 32'(PB_WE), 32'h0);

        // Restarted sweep from 0; a second CLR_START mid-sweep is ignored
        tick();
        CLR_START = 1'b1; CLR_DATA = 4'h6;
        tick();
        CLR_START = 1'b0;
        nw = 0; bad = 0; nb = 0; got = 1'b0;
        for (int i = 0; i < 20000 && !got; i++) begin
            @(negedge VGA_CLK);
            if (CLR_BUSY) nb++;
            if (PB_WE) begin
                if (int'(PB_WA) != nw || PB_DATA != 4'h6) bad++;
                nw++;
            end
            if (CLR_DONE) got = 1'b1;
            else begin
                tick();
                CLR_START = (i == 50);
                CLR_DATA  = 4'h9;
            end
        end
        CLR_START = 1'b0;
        chk("refill_done_seen", 32'(got), 32'h1);
        chk("refill_busy_len",  32'(nb),  32'd19200);
        chk("refill_writes",    32'(nw),  32'd19200);
        chk("refill_bad",       32'(bad), 32'h0);
        chk("refill_last_wa",   32'(PB_WA), 32'd19199);

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
